// File: rtl/pipe_pkg.sv
// Shared types and constants for the elastic pipeline-stage register and its
// optional statistics block.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } pipe_state_t;

    localparam logic [31:0] PIPE_NOP    = 32'h0000_0000;
    localparam int          STALL_CNT_W = 32;
    localparam int          FLUSH_CNT_W = 16;

endpackage

// File: rtl/pipe_stage_stats.sv
// Saturating stall/flush event counters for one pipeline stage.
// Only instantiated when PIPE_STAGE_STATS_EN is defined.
module pipe_stage_stats
    import pipe_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_stall,
    input  logic                   i_flush_held,
    output logic [STALL_CNT_W-1:0] o_stall_cnt,
    output logic [FLUSH_CNT_W-1:0] o_flush_cnt
);

    logic [STALL_CNT_W-1:0] r_stall_cnt;
    logic [FLUSH_CNT_W-1:0] r_flush_cnt;

    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (i_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (i_flush_held && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign o_stall_cnt = r_stall_cnt;
    assign o_flush_cnt = r_flush_cnt;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic ready/valid pipeline-stage register with a 2-entry skid buffer.
// Define PIPE_STAGE_STATS_EN to add the stall_cnt/flush_cnt statistics ports.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W = 64,
    parameter logic [DATA_W-1:0] BUBBLE = DATA_W'(PIPE_NOP)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [DATA_W-1:0]      in_data,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic [DATA_W-1:0]      out_data,
    input  logic                   out_ready,
    input  logic                   flush
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [STALL_CNT_W-1:0] stall_cnt,
    output logic [FLUSH_CNT_W-1:0] flush_cnt
`endif
);

    pipe_state_t       r_state;
    pipe_state_t       w_state_next;
    logic [DATA_W-1:0] r_main;
    logic [DATA_W-1:0] r_skid;
    logic [DATA_W-1:0] w_main_next;
    logic [DATA_W-1:0] w_skid_next;
    logic              w_accept;
    logic              w_consume;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= EMPTY;
            r_main  <= BUBBLE;
            r_skid  <= BUBBLE;
        end else begin
            r_state <= w_state_next;
            r_main  <= w_main_next;
            r_skid  <= w_skid_next;
        end
    end

    // Handshake outputs decode the state register only, so in_ready never
    // has a combinational path from out_ready or flush.
    always_comb begin
        w_state_next = r_state;
        w_main_next  = r_main;
        w_skid_next  = r_skid;
        in_ready     = (r_state != FULL);
        out_valid    = (r_state != EMPTY);
        w_accept     = in_valid & in_ready;
        w_consume    = out_valid & out_ready;

        if (flush) begin
            w_state_next = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        w_state_next = HALF;
                        w_main_next  = in_data;
                    end
                end
                HALF: begin
                    if (w_accept && w_consume) begin
                        w_main_next  = in_data;
                    end else if (w_accept) begin
                        w_state_next = FULL;
                        w_skid_next  = in_data;
                    end else if (w_consume) begin
                        w_state_next = EMPTY;
                    end
                end
                FULL: begin
                    if (w_consume) begin
                        w_state_next = HALF;
                        w_main_next  = r_skid;
                    end
                end
                default: begin
                    w_state_next = EMPTY;
                end
            endcase
        end
    end

    assign out_data = out_valid ? r_main : BUBBLE;

`ifdef PIPE_STAGE_STATS_EN
    pipe_stage_stats u_stats (
        .clk          (clk),
        .rst          (rst),
        .i_stall      (out_valid & ~out_ready),
        .i_flush_held (flush & out_valid),
        .o_stall_cnt  (stall_cnt),
        .o_flush_cnt  (flush_cnt)
    );
`else
    // Statistics disabled: the stage is purely the handshake datapath.
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed vector table, an in_ready
// isolation sequence, optional statistics checks and a randomized scoreboard run.
module tb_pipe_stage_reg;

    localparam int DATA_W = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready = 1'b0;
    logic              flush = 1'b0;
`ifdef PIPE_STAGE_STATS_EN
    logic [31:0]       stall_cnt;
    logic [15:0]       flush_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .flush     (flush)
`ifdef PIPE_STAGE_STATS_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    typedef struct {
        logic              rs;
        logic              iv;
        logic [DATA_W-1:0] d;
        logic              ordy;
        logic              fl;
        logic              ev;
        logic [DATA_W-1:0] ed;
        logic              er;
    } vec_t;

    vec_t tbl[$];
    logic [DATA_W-1:0] model_q[$];

    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic rs, input logic iv, input logic [DATA_W-1:0] d,
                       input logic ordy, input logic fl,
                       input logic ev, input logic [DATA_W-1:0] ed, input logic er);
        vec_t v;
        v.rs = rs; v.iv = iv; v.d = d; v.ordy = ordy; v.fl = fl;
        v.ev = ev; v.ed = ed; v.er = er;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic rs, input logic iv, input logic [DATA_W-1:0] d,
                         input logic ordy, input logic fl);
        rst = rs; in_valid = iv; in_data = d; out_ready = ordy; flush = fl;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic ir0;
        int   n_deliv;
        bit   acc, con;

        //  rs iv data    ordy fl | exp valid data  ready
        // streaming at full throughput
        add(1, 0, 64'h00,  0, 0,   0, 64'h00, 1);
        add(0, 1, 64'h11,  1, 0,   1, 64'h11, 1);
        add(0, 1, 64'h22,  1, 0,   1, 64'h22, 1);
        add(0, 1, 64'h33,  1, 0,   1, 64'h33, 1);
        add(0, 0, 64'h00,  1, 0,   0, 64'h00, 1);
        // stall fills the skid entry, then drains in order
        add(0, 1, 64'h11,  1, 0,   1, 64'h11, 1);
        add(0, 1, 64'h22,  0, 0,   1, 64'h11, 0);
        add(0, 1, 64'hEE,  0, 0,   1, 64'h11, 0);
        add(0, 0, 64'h00,  1, 0,   1, 64'h22, 1);
        add(0, 0, 64'h00,  1, 0,   0, 64'h00, 1);
        // flush in FULL with a same-cycle input
        add(0, 1, 64'h55,  0, 0,   1, 64'h55, 1);
        add(0, 1, 64'h66,  0, 0,   1, 64'h55, 0);
        add(0, 1, 64'h44,  0, 1,   0, 64'h00, 1);
        add(0, 0, 64'h00,  1, 0,   0, 64'h00, 1);
        // flush in HALF with a same-cycle accept and consume
        add(0, 1, 64'hAA,  1, 0,   1, 64'hAA, 1);
        add(0, 1, 64'hBB,  1, 1,   0, 64'h00, 1);
        add(0, 0, 64'h00,  1, 0,   0, 64'h00, 1);
        // reset beats flush and handshakes in FULL
        add(0, 1, 64'h77,  0, 0,   1, 64'h77, 1);
        add(0, 1, 64'h88,  0, 0,   1, 64'h77, 0);
        add(1, 1, 64'h99,  1, 1,   0, 64'h00, 1);
        add(0, 0, 64'h00,  1, 0,   0, 64'h00, 1);

        @(negedge clk);
        foreach (tbl[i]) begin
            drive(tbl[i].rs, tbl[i].iv, tbl[i].d, tbl[i].ordy, tbl[i].fl);
            step();
            $display("vec %0d: in_v=%0d in_d=%h o_rdy=%0d fl=%0d rst=%0d -> out_v=%0d out_d=%h in_rdy=%0d",
                     i, tbl[i].iv, tbl[i].d, tbl[i].ordy, tbl[i].fl, tbl[i].rs,
                     out_valid, out_data, in_ready);
            check($sformatf("vec%0d out_valid", i), 64'(out_valid), 64'(tbl[i].ev));
            check($sformatf("vec%0d out_data", i),  out_data,       tbl[i].ed);
            check($sformatf("vec%0d in_ready", i),  64'(in_ready),  64'(tbl[i].er));
        end

        // in_ready must stay put while out_ready/flush wiggle without a clock edge
        drive(0, 1, 64'hC1, 0, 0); step();
        drive(0, 1, 64'hC2, 0, 0); step();
        drive(0, 0, 64'h0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            out_ready = k[0];
            flush     = k[1];
            #1;
            $display("iso %0d: o_rdy=%0d fl=%0d -> in_rdy=%0d", k, out_ready, flush, in_ready);
            check($sformatf("iso%0d in_ready", k), 64'(in_ready), 64'(0));
        end
        drive(1, 0, 64'h0, 0, 0); step();

`ifdef PIPE_STAGE_STATS_EN
        check("stats stall_cnt reset", 64'(stall_cnt), 64'(0));
        check("stats flush_cnt reset", 64'(flush_cnt), 64'(0));
        drive(0, 1, 64'hD1, 0, 0); step();
        drive(0, 0, 64'h0, 0, 0);
        for (int k = 0; k < 5; k++) step();
        drive(0, 0, 64'h0, 1, 1); step();
        drive(0, 0, 64'h0, 0, 0);
        $display("stats: stall_cnt=%0d flush_cnt=%0d", stall_cnt, flush_cnt);
        check("stats stall_cnt", 64'(stall_cnt), 64'(5));
        check("stats flush_cnt", 64'(flush_cnt), 64'(1));
        drive(1, 0, 64'h0, 0, 0); step();
`endif

        // randomized run against a 2-deep FIFO scoreboard
        drive(0, 0, 64'h0, 0, 0);
        model_q.delete();
        n_deliv = 0;
        for (int c = 0; c < 3000; c++) begin
            check("rnd out_valid", 64'(out_valid), 64'(model_q.size() > 0));
            check("rnd out_data", out_data, (model_q.size() > 0) ? model_q[0] : 64'h0);
            check("rnd in_ready", 64'(in_ready), 64'(model_q.size() < 2));
            ir0 = in_ready;
            out_ready = ~out_ready;
            #1;
            check("rnd in_ready stable", 64'(in_ready), 64'(ir0));
            in_valid  = ($urandom_range(99) < 70);
            in_data   = {$urandom, $urandom};
            out_ready = ($urandom_range(99) < 60);
            flush     = ($urandom_range(99) < 2);
            @(posedge clk);
            acc = in_valid && (model_q.size() < 2);
            con = out_ready && (model_q.size() > 0);
            if (con) begin
                n_deliv++;
                $display("rnd cycle %0d: deliver %h%s", c, model_q[0], flush ? " (flush)" : "");
            end
            if (flush) begin
                model_q.delete();
            end else begin
                if (con) void'(model_q.pop_front());
                if (acc) model_q.push_back(in_data);
            end
            @(negedge clk);
        end
        $display("random run delivered %0d entries", n_deliv);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
